// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and sizing defaults.
package period_meter_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int          DEFAULT_CNT_W = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM_HIGH,
    ST_HIGH,
    ST_LOW
  } state_e;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Multi-flop synchronizer plus history flop; emits the synchronized level and
// single-cycle rise/fall strobes. Also usable for button inputs.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow input in clk cycles, with a sticky
// timeout when no edge arrives before the counter saturates.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_valid;
  logic             r_timeout;

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_cnt_full;
  logic w_restart;
  logic w_counting;
  logic w_capture;
  logic w_publish;
  logic w_timeout;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .clr     (clr),
    .i_sig   (sig_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge     = w_rise | w_fall;
  assign w_cnt_full = (r_cnt == CNT_MAX);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_restart  = 1'b0;
    w_counting = 1'b0;
    w_capture  = 1'b0;
    w_publish  = 1'b0;
    w_timeout  = 1'b0;
    if (!en) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: w_next = ST_ARM_HIGH;
        ST_ARM_HIGH: begin
          // Partial interval before the first rise is discarded.
          if (w_rise) begin
            w_next    = ST_HIGH;
            w_restart = 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_next     = ST_LOW;
            w_capture  = 1'b1;
            w_counting = 1'b1;
          end else if (w_cnt_full && !w_edge) begin
            w_next    = ST_ARM_HIGH;
            w_timeout = 1'b1;
          end else begin
            w_counting = 1'b1;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_next    = ST_HIGH;
            w_publish = 1'b1;
            w_restart = 1'b1;
          end else if (w_cnt_full && !w_edge) begin
            w_next    = ST_ARM_HIGH;
            w_timeout = 1'b1;
          end else begin
            w_counting = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_shadow    <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_publish;

      if (w_restart) begin
        r_cnt  <= CNT_ONE;
        r_hcnt <= CNT_ONE;
      end else if (w_counting) begin
        r_cnt <= sat_inc(r_cnt);
        if (r_state == ST_HIGH && w_level) r_hcnt <= sat_inc(r_hcnt);
      end else begin
        r_cnt  <= '0;
        r_hcnt <= '0;
      end

      if (w_capture) r_shadow <= r_hcnt;

      if (w_publish) begin
        r_period    <= r_cnt;
        r_high_time <= r_shadow;
        r_timeout   <= 1'b0;
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with CNT_W=8 so the timeout is reachable quickly.
module tb_period_meter;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clr;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  int n_valid;
  int consec;
  int skip_left;
  int exp_p;
  int exp_h;
  bit prev_valid;
  bit chk_vals;

  period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive sig_in for one cycle, then sample outputs on the falling edge.
  task automatic step(input logic s);
    sig_in = s;
    @(negedge clk);
    if (valid === 1'b1) begin
      n_valid++;
      if (prev_valid) consec++;
      if (skip_left > 0) skip_left--;
      else if (chk_vals) begin
        check("period", 32'(period), exp_p);
        check("high_time", 32'(high_time), exp_h);
      end
    end
    prev_valid = (valid === 1'b1);
  endtask

  // n periods of h high / l low, then 4 low cycles so every pending valid lands here.
  task automatic wave(input int h, input int l, input int n, input int exp_valids,
                      input int skip, input int ep, input int eh);
    n_valid   = 0;
    skip_left = skip;
    chk_vals  = 1'b1;
    exp_p     = ep;
    exp_h     = eh;
    repeat (n) begin
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
    repeat (4) step(1'b0);
    check("valid_count", n_valid, exp_valids);
    check("timeout_clear", 32'(timeout), 0);
    chk_vals = 1'b0;
  endtask

  initial begin
    clr        = 1'b0;
    en         = 1'b0;
    sig_in     = 1'b0;
    n_valid    = 0;
    consec     = 0;
    skip_left  = 0;
    exp_p      = 0;
    exp_h      = 0;
    prev_valid = 1'b0;
    chk_vals   = 1'b0;

    // Reset state
    repeat (3) step(1'b0);
    check("rst_period", 32'(period), 0);
    check("rst_high_time", 32'(high_time), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_busy", 32'(busy), 0);
    clr = 1'b1;
    step(1'b0);
    check("idle_busy", 32'(busy), 0);
    en = 1'b1;
    step(1'b0);
    check("armed_busy", 32'(busy), 1);
    repeat (2) step(1'b0);

    // 8-cycle period, 4 high: first rise gives no valid
    wave(4, 4, 3, 2, 0, 8, 4);

    // Duty 2/8, then 5-cycle period with 3 high; first valid of each spans the switch
    wave(2, 6, 3, 3, 1, 8, 2);
    wave(3, 2, 3, 3, 1, 5, 3);

    // Minimum period
    consec = 0;
    wave(1, 1, 6, 6, 1, 2, 1);
    check("no_back_to_back_valid", consec, 0);

    // Timeout: last interval before the hold is 4 high + 4 low + 4 flush = 12
    wave(4, 4, 3, 3, 1, 8, 4);
    n_valid   = 0;
    skip_left = 0;
    chk_vals  = 1'b1;
    exp_p     = 12;
    exp_h     = 4;
    for (int i = 0; i < 258; i++) begin
      step(1'b1);
      if (i == 256) check("timeout_before", 32'(timeout), 0);
      if (i == 257) check("timeout_at_255", 32'(timeout), 1);
    end
    chk_vals = 1'b0;
    check("timeout_valid_count", n_valid, 1);
    check("timeout_hold_period", 32'(period), 12);
    check("timeout_hold_high", 32'(high_time), 4);
    check("timeout_rearm_busy", 32'(busy), 1);
    // Input is already high: the rise of period 2 arms, periods 3 and 4 report
    wave(4, 4, 4, 2, 0, 8, 4);

    // en dropped mid-LOW
    en = 1'b0;
    n_valid = 0;
    repeat (3) begin
      step(1'b0);
      check("en_gap_busy", 32'(busy), 0);
      check("en_gap_valid", 32'(valid), 0);
      check("en_gap_period_hold", 32'(period), 8);
    end
    en = 1'b1;
    wave(4, 4, 3, 2, 0, 8, 4);

    // Reset pulse mid-HIGH
    repeat (4) step(1'b1);
    clr = 1'b0;
    step(1'b0);
    check("clr_period", 32'(period), 0);
    check("clr_high_time", 32'(high_time), 0);
    check("clr_valid", 32'(valid), 0);
    check("clr_timeout", 32'(timeout), 0);
    check("clr_busy", 32'(busy), 0);
    clr = 1'b1;
    n_valid = 0;
    repeat (3) step(1'b0);
    check("clr_no_spurious_valid", n_valid, 0);
    wave(4, 4, 3, 2, 0, 8, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
